// File: rtl/sort_pkg.sv
// Shared types for the BWT merge sort scheduler:
// row layout, default geometry, bank encoding and FSM states.
package sort_pkg;

    localparam int ROWS_DEF   = 8;
    localparam int COLUMN_DEF = 3;

    localparam logic BANK_A = 1'b0;
    localparam logic BANK_B = 1'b1;

    typedef logic [COLUMN_DEF-1:0][7:0] row_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_FLUSH,
        S_MERGE,
        S_NEXT,
        S_DONE
    } sched_state_t;

endpackage

// File: rtl/merge_pass_cnt.sv
// Nested column / run-width / base counter for the merge sort scheduler.
// One advance per run pair; last flags the final pair of column 0.
module merge_pass_cnt
    import sort_pkg::*;
#(
    parameter int ROWS   = ROWS_DEF,
    parameter int COLUMN = COLUMN_DEF,
    parameter int ADDR_W = $clog2(ROWS),
    parameter int LOG2R  = $clog2(ROWS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_i,
    input  logic              advance_i,
    output logic [1:0]        col_o,
    output logic [ADDR_W:0]   w_o,
    output logic [ADDR_W-1:0] base_o,
    output logic              bank_o,
    output logic              last_o
);

    localparam int              COL_I   = COLUMN - 1;
    localparam int              WEND_I  = 1 << LOG2R;
    localparam logic [1:0]      COL_TOP = COL_I[1:0];
    localparam logic [ADDR_W:0] ROWS_V  = ROWS[ADDR_W:0];
    localparam logic [ADDR_W:0] W_END   = WEND_I[ADDR_W:0];
    localparam logic [ADDR_W:0] W_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    logic [1:0]      col_q, col_d;
    logic [ADDR_W:0] w_q, w_d;
    logic [ADDR_W:0] base_q, base_d;
    logic            bank_q, bank_d;
    logic [ADDR_W:0] w2, nbase;
    logic            pass_end, col_end;

    assign w2       = w_q << 1;
    assign nbase    = base_q + w2;
    assign pass_end = (nbase == ROWS_V);
    assign col_end  = pass_end && (w2 == W_END);

    always_comb begin
        col_d  = col_q;
        w_d    = w_q;
        base_d = base_q;
        bank_d = bank_q;
        if (init_i) begin
            col_d  = COL_TOP;
            w_d    = W_ONE;
            base_d = '0;
            bank_d = BANK_A;
        end else if (advance_i) begin
            base_d = nbase;
            if (pass_end) begin
                base_d = '0;
                bank_d = ~bank_q;
                w_d    = w2;
            end
            // col holds at 0 on the final pair instead of wrapping
            if (col_end) begin
                w_d = W_ONE;
                if (col_q != 2'd0)
                    col_d = col_q - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q  <= COL_TOP;
            w_q    <= W_ONE;
            base_q <= '0;
            bank_q <= BANK_A;
        end else begin
            col_q  <= col_d;
            w_q    <= w_d;
            base_q <= base_d;
            bank_q <= bank_d;
        end
    end

    assign col_o  = col_q;
    assign w_o    = w_q;
    assign base_o = base_q[ADDR_W-1:0];
    assign bank_o = bank_q;
    assign last_o = col_end && (col_q == 2'd0);

endmodule

// File: rtl/merge_sort_sched.sv
// Sequencer for the two-FIFO row merger (LSD bottom-up merge sort).
// Optional SORT_CYCLE_CNT_EN builds a busy-cycle counter on cycle_cnt.
module merge_sort_sched
    import sort_pkg::*;
#(
    parameter int ROWS   = ROWS_DEF,
    parameter int COLUMN = COLUMN_DEF,
    parameter int ADDR_W = $clog2(ROWS),
    parameter int LOG2R  = $clog2(ROWS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              result_bank,
    output logic [1:0]        sort_num,
    output logic              buf_rd_en,
    output logic [ADDR_W-1:0] buf_rd_addr,
    output logic              buf_rd_bank,
    output logic              fifo_L_wr,
    output logic              fifo_R_wr,
    output logic              merge_hold,
    input  logic              merger_wr,
    output logic              wb_en,
    output logic [ADDR_W-1:0] wb_addr,
    output logic              wb_bank,
    output logic [31:0]       cycle_cnt
);

    localparam logic [ADDR_W:0] W_ONE = {{ADDR_W{1'b0}}, 1'b1};

    sched_state_t    state_q;
    logic [ADDR_W:0] idx_q, out_cnt_q;
    logic            busy_q, done_q, hold_q;
    logic            res_bank_q, l_wr_q, r_wr_q;

    logic [1:0]        col;
    logic [ADDR_W:0]   w;
    logic [ADDR_W-1:0] base;
    logic              bank, last;
    logic              init, advance, w_last, pair_last;

    assign init      = (state_q == S_IDLE) && start;
    assign advance   = (state_q == S_NEXT);
    assign w_last    = (idx_q == (w - W_ONE));
    assign pair_last = (out_cnt_q == ((w << 1) - W_ONE));

    merge_pass_cnt #(
        .ROWS   (ROWS),
        .COLUMN (COLUMN),
        .ADDR_W (ADDR_W),
        .LOG2R  (LOG2R)
    ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .init_i    (init),
        .advance_i (advance),
        .col_o     (col),
        .w_o       (w),
        .base_o    (base),
        .bank_o    (bank),
        .last_o    (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            out_cnt_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hold_q     <= 1'b1;
            res_bank_q <= BANK_A;
            l_wr_q     <= 1'b0;
            r_wr_q     <= 1'b0;
        end else begin
            l_wr_q <= (state_q == S_LOAD_A);
            r_wr_q <= (state_q == S_LOAD_B);
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_LOAD_A;
                        busy_q  <= 1'b1;
                        idx_q   <= '0;
                    end
                end
                S_LOAD_A: begin
                    if (w_last) begin
                        idx_q   <= '0;
                        state_q <= S_LOAD_B;
                    end else begin
                        idx_q <= idx_q + W_ONE;
                    end
                end
                S_LOAD_B: begin
                    if (w_last) begin
                        idx_q   <= '0;
                        state_q <= S_FLUSH;
                    end else begin
                        idx_q <= idx_q + W_ONE;
                    end
                end
                S_FLUSH: begin
                    state_q <= S_MERGE;
                    hold_q  <= 1'b0;
                end
                S_MERGE: begin
                    if (merger_wr) begin
                        if (pair_last) begin
                            out_cnt_q <= '0;
                            hold_q    <= 1'b1;
                            state_q   <= S_NEXT;
                        end else begin
                            out_cnt_q <= out_cnt_q + W_ONE;
                        end
                    end
                end
                S_NEXT: begin
                    // the final pair always ends a pass, so the bank flips
                    if (last) begin
                        state_q    <= S_DONE;
                        done_q     <= 1'b1;
                        res_bank_q <= ~bank;
                    end else begin
                        state_q <= S_LOAD_A;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result_bank = res_bank_q;
    assign sort_num    = col;
    assign merge_hold  = hold_q;
    assign fifo_L_wr   = l_wr_q;
    assign fifo_R_wr   = r_wr_q;

    assign buf_rd_en   = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
    assign buf_rd_bank = bank;
    assign buf_rd_addr = (state_q == S_LOAD_B)
                       ? base + w[ADDR_W-1:0] + idx_q[ADDR_W-1:0]
                       : base + idx_q[ADDR_W-1:0];

    assign wb_en   = merger_wr && (state_q == S_MERGE);
    assign wb_addr = base + out_cnt_q[ADDR_W-1:0];
    assign wb_bank = (bank == BANK_A) ? BANK_B : BANK_A;

`ifdef SORT_CYCLE_CNT_EN
    logic [31:0] cyc_q;

    always_ff @(posedge clk) begin
        if (rst)
            cyc_q <= '0;
        else if (init)
            cyc_q <= '0;
        else if ((state_q != S_IDLE) && (state_q != S_DONE))
            cyc_q <= cyc_q + 32'd1;
    end

    assign cycle_cnt = cyc_q;
`else
    assign cycle_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_merge_sort_sched.sv
// Randomised bench for merge_sort_sched: models the row buffer, the two
// merger FIFOs and a merger, and checks results against a stable sort.
module tb_merge_sort_sched;
    import sort_pkg::*;

    localparam int ROWS   = 8;
    localparam int COLUMN = 3;
    localparam int AW     = 3;
    localparam int SORT_CYC = 186;
`ifdef SORT_CYCLE_CNT_EN
    localparam logic [31:0] EXP_CNT = 32'd186;
`else
    localparam logic [31:0] EXP_CNT = 32'd0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          merger_wr = 1'b0;
    logic          busy, done, result_bank;
    logic [1:0]    sort_num;
    logic          buf_rd_en, buf_rd_bank;
    logic [AW-1:0] buf_rd_addr, wb_addr;
    logic          fifo_L_wr, fifo_R_wr, merge_hold;
    logic          wb_en, wb_bank;
    logic [31:0]   cycle_cnt;

    always #5 clk = ~clk;

    merge_sort_sched #(.ROWS(ROWS), .COLUMN(COLUMN)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .result_bank (result_bank),
        .sort_num    (sort_num),
        .buf_rd_en   (buf_rd_en),
        .buf_rd_addr (buf_rd_addr),
        .buf_rd_bank (buf_rd_bank),
        .fifo_L_wr   (fifo_L_wr),
        .fifo_R_wr   (fifo_R_wr),
        .merge_hold  (merge_hold),
        .merger_wr   (merger_wr),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_bank     (wb_bank),
        .cycle_cnt   (cycle_cnt)
    );

    row_t mem [2][ROWS];
    row_t qL[$];
    row_t qR[$];
    row_t rd_data;
    bit   stall = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: buffer read data, FIFO pushes, merger output, write-back.
    task automatic cyc();
        logic tk_l;
        row_t merged;
        tk_l = 1'b1;
        merged = '0;
        @(negedge clk);
        if (fifo_L_wr) qL.push_back(rd_data);
        if (fifo_R_wr) qR.push_back(rd_data);
        if (buf_rd_en) rd_data = mem[buf_rd_bank][buf_rd_addr];
        else rd_data = 'x;
        merger_wr = 1'b0;
        if (merge_hold === 1'b0 && (qL.size() + qR.size()) > 0 &&
            !(stall && $urandom_range(0, 2) == 0)) begin
            if (qR.size() == 0) tk_l = 1'b1;
            else if (qL.size() == 0) tk_l = 1'b0;
            else tk_l = (qL[0][sort_num] <= qR[0][sort_num]);
            merged = tk_l ? qL[0] : qR[0];
            merger_wr = 1'b1;
        end
        #1;
        if (wb_en === 1'b1) begin
            mem[wb_bank][wb_addr] = merged;
            if (tk_l) void'(qL.pop_front());
            else void'(qR.pop_front());
        end
    endtask

    function automatic logic [23:0] kv(input row_t r);
        return {r[0], r[1], r[2]};
    endfunction

    task automatic ref_sort(input row_t src[ROWS], output row_t dst[ROWS]);
        row_t t;
        dst = src;
        for (int i = 1; i < ROWS; i++)
            for (int j = i; j > 0 && kv(dst[j-1]) > kv(dst[j]); j--) begin
                t = dst[j];
                dst[j] = dst[j-1];
                dst[j-1] = t;
            end
    endtask

    task automatic chk_sorted(input string tag, input row_t src[ROWS]);
        row_t exp[ROWS];
        ref_sort(src, exp);
        for (int i = 0; i < ROWS; i++)
            chk($sformatf("%s_row%0d", tag, i), 32'(mem[1][i]), 32'(exp[i]));
    endtask

    task automatic fill(input int maxv);
        for (int i = 0; i < ROWS; i++)
            for (int c = 0; c < COLUMN; c++) begin
                mem[0][i][c] = 8'($urandom_range(0, maxv));
                mem[1][i][c] = 8'($urandom);
            end
    endtask

    // Expected strobes of the first pair: {rd_en, addr, L, R, hold, wb_en, wb_addr, wb_bank}
    function automatic logic [11:0] pair_exp(input int n);
        case (n)
            0: return {1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
            1: return {1'b1, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0};
            2: return {1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0};
            3: return {1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1};
            4: return {1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1};
            5: return {1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
            default: return {1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
        endcase
    endfunction

    task automatic run_sort(input bit kick, input bit hold, input bit pair_chk,
                            output int busy_n);
        int n;
        logic [11:0] got;
        n = 0;
        busy_n = 0;
        if (kick) start = 1'b1;
        do begin
            cyc();
            if (!hold) start = 1'b0;
            if (busy === 1'b1 && done !== 1'b1) busy_n++;
            if (pair_chk && n < 7) begin
                got = {buf_rd_en, buf_rd_en ? buf_rd_addr : 3'd0,
                       fifo_L_wr, fifo_R_wr, merge_hold, wb_en,
                       wb_en ? {wb_addr, wb_bank} : 4'd0};
                chk($sformatf("pair0_c%0d", n), 32'(got), 32'(pair_exp(n)));
            end
            n++;
        end while (done !== 1'b1 && n < 4000);
        chk("done_seen", 32'(done), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        row_t src[ROWS];
        row_t snap[ROWS];
        int   bn;
        int   n;

        rst = 1'b1;
        repeat (2) cyc();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_hold", 32'(merge_hold), 32'd1);
        chk("rst_strobes", 32'({buf_rd_en, fifo_L_wr, fifo_R_wr, wb_en}), 32'd0);
        chk("rst_rbank", 32'(result_bank), 32'd0);
        chk("rst_col", 32'(sort_num), 32'd2);
        chk("rst_cnt", cycle_cnt, 32'd0);
        rst = 1'b0;
        cyc();

        fill(255);
        src = mem[0];
        run_sort(1'b1, 1'b0, 1'b1, bn);
        chk("t1_busy_cyc", 32'(bn), 32'(SORT_CYC));
        chk("t1_rbank", 32'(result_bank), 32'd1);
        chk("t1_cnt", cycle_cnt, EXP_CNT);
        chk_sorted("t1", src);
        cyc();
        chk("t1_pulse", 32'({busy, done}), 32'd0);
        chk("t1_cnt_hold", cycle_cnt, EXP_CNT);

        // heavy ties and a stalling merger
        for (int k = 0; k < 3; k++) begin
            fill(k == 1 ? 0 : 1);
            src = mem[0];
            stall = 1'b1;
            run_sort(1'b1, 1'b0, 1'b0, bn);
            stall = 1'b0;
            chk($sformatf("t2_%0d_rbank", k), 32'(result_bank), 32'd1);
            chk_sorted($sformatf("t2_%0d", k), src);
            cyc();
        end

        // reset in the middle of a column-1 merge
        fill(255);
        start = 1'b1;
        cyc();
        start = 1'b0;
        n = 0;
        while (!(sort_num === 2'd1 && merge_hold === 1'b0) && n < 1000) begin
            cyc();
            n++;
        end
        chk("t3_mid_merge", 32'(n < 1000), 32'd1);
        merger_wr = 1'b0;
        rst = 1'b1;
        qL.delete();
        qR.delete();
        cyc();
        chk("t3_busy", 32'(busy), 32'd0);
        chk("t3_hold", 32'(merge_hold), 32'd1);
        chk("t3_strobes",
            32'({buf_rd_en, fifo_L_wr, fifo_R_wr, wb_en, done}), 32'd0);
        chk("t3_col", 32'(sort_num), 32'd2);
        rst = 1'b0;
        cyc();
        fill(255);
        src = mem[0];
        run_sort(1'b1, 1'b0, 1'b0, bn);
        chk("t3_busy_cyc", 32'(bn), 32'(SORT_CYC));
        chk("t3_cnt", cycle_cnt, EXP_CNT);
        chk_sorted("t3", src);
        cyc();

        // start held through the whole sort and into DONE
        fill(200);
        src = mem[0];
        run_sort(1'b1, 1'b1, 1'b0, bn);
        chk("t4_busy_cyc", 32'(bn), 32'(SORT_CYC));
        chk_sorted("t4", src);
        snap = mem[0];
        cyc();
        chk("t4_idle", 32'(busy), 32'd0);
        cyc();
        chk("t4_restart", 32'(busy), 32'd1);
        start = 1'b0;
        run_sort(1'b0, 1'b0, 1'b0, bn);
        chk("t4b_busy_cyc", 32'(bn + 1), 32'(SORT_CYC));
        chk("t4b_cnt", cycle_cnt, EXP_CNT);
        chk_sorted("t4b", snap);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/merge_sort_sched.md
Name: merge_sort_sched

Overview:
Sequencer for the two-FIFO row merger in the BWT sort datapath. It runs a stable LSD bottom-up merge sort over ROWS rows of COLUMN bytes held in a two-bank (ping-pong) row buffer, one key column at a time from COLUMN-1 down to 0. For each run pair it loads run A into FIFO L and run B into FIFO R, then releases the merger, writes its output back into the opposite bank, and selects the key column (sort_num).

Parameters:
ROWS, 8, rows to sort; power of 2, ≥2
COLUMN, 3, bytes per row = number of key columns
ADDR_W, $clog2(ROWS), row address width
LOG2R, $clog2(ROWS), merge passes per column

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  begin sort; sampled only in IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse in DONE
result_bank  out  1  bank holding the sorted rows; valid from done onward
sort_num  out  2  key column for the merger (= col)
buf_rd_en  out  1  row-buffer read; data arrives exactly 1 cycle later
buf_rd_addr  out  ADDR_W  read address
buf_rd_bank  out  1  source bank
fifo_L_wr  out  1  push buffer read data into FIFO L
fifo_R_wr  out  1  push buffer read data into FIFO R
merge_hold  out  1  when high, datapath forces merger empty_FIFO_L/R inputs high
merger_wr  in  1  merger wr_fifo strobe, one merged row per cycle
wb_en  out  1  row-buffer write of merged_array; equals merger_wr in MERGE
wb_addr  out  ADDR_W  base + out_cnt
wb_bank  out  1  ~buf_rd_bank
cycle_cnt  out  32  see Optional Feature

Behaviour:
- Reset: rst synchronous, active-high; clock clk. Resets state=IDLE, col=COLUMN-1, w=1, base=0, idx=0, out_cnt=0, bank=0, result_bank=0. All strobes are 0, merge_hold=1, and busy, done, cycle_cnt are 0. Merger FIFOs use the same rst, so a mid-sort reset aborts cleanly. Buffer contents are undefined after an abort.
- States: IDLE, LOAD_A, LOAD_B, FLUSH, MERGE, NEXT, DONE.
- IDLE: on start go to LOAD_A with col=COLUMN-1, w=1, base=0, bank=0. start is ignored in every other state.
- LOAD_A: for w cycles, buf_rd_en=1 and addr=base+idx. Then idx=0 and go to LOAD_B.
- LOAD_B: for w cycles, addr=base+w+idx. Then go to FLUSH.
- fifo_L_wr and fifo_R_wr are the read enables of LOAD_A and LOAD_B registered by one cycle. The last R push lands in FLUSH.
- FLUSH: lasts 1 cycle, then go to MERGE.
- MERGE: merge_hold=0. Each merger_wr increments out_cnt. When out_cnt reaches 2w-1 and merger_wr=1, go to NEXT. merger_wr outside MERGE is ignored.
- merge_hold=1 in all states except MERGE.
- NEXT: out_cnt=0, base += 2w. If base+2w==ROWS, then base=0, bank toggles, and w doubles.
- NEXT, end of column: if the doubled w would equal ROWS, then w=1 and col decrements. When col was 0, go to DONE.
- DONE: done=1, result_bank=bank. Go to IDLE next cycle.
- Arithmetic: base, idx and out_cnt are ADDR_W+1 bits to avoid wrap at ROWS. Addresses are truncated to ADDR_W.
- Latency with an ideal merger (one write per cycle): per pair 4w+2 cycles; per pass 2·ROWS + ROWS/w.
- Totals: total passes = COLUMN·LOG2R, and result_bank = parity of total passes.

Optional Feature:
Macro SORT_CYCLE_CNT_EN.
- Defined: a 32-bit counter clears on start in IDLE and increments each cycle in LOAD_A..NEXT. cycle_cnt holds the final count from DONE until the next start.
- Undefined: cycle_cnt is tied to 0 and no counter logic is built.

Decomposition:
- Package sort_pkg: state enum sched_state_t, row_t (byte array [COLUMN]), the COLUMN and ROWS defaults, and the bank-select encoding.
- One sub-module, merge_pass_cnt: the nested col/w/base counter. It takes advance (pulsed in NEXT) and returns col, w, base, bank, and last (final pass complete).

Test Plan:
- ROWS=8, COLUMN=3, random rows, start pulse → done after 186 busy cycles of LOAD_A..NEXT. result_bank=1. Bank 1 rows are ordered by (col0, col1, col2), stable.
- Rows with all-equal keys → output order equals input order (stability; L wins ties).
- First pair, w=1 → rd addr 0 with fifo_L_wr at cycle+1, rd addr 1 with fifo_R_wr at cycle+2. merge_hold falls only in MERGE. wb_addr 0 then 1 to bank 1.
- rst asserted mid-MERGE of col 1 → next cycle IDLE, busy=0, merge_hold=1, no strobes. A new start completes a correct sort.
- start held high in DONE and during busy → exactly one sort runs. Restart occurs only after returning to IDLE.
- SORT_CYCLE_CNT_EN defined → cycle_cnt=186 after done. Undefined → cycle_cnt=0 throughout.
